// File: rtl/pipe_stage_buf.sv
// Two-entry ready/valid skid buffer used as an OTTER pipeline stage register.
// Optional PIPE_STAGE_BUF_PERF_EN adds a saturating stall_cnt output.
module pipe_stage_buf #(
    parameter int          XLEN     = 32,
    parameter int          DATA_W   = 64,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [XLEN-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int EW = 32 + XLEN + DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [EW-1:0] main_q, main_d;
    logic [EW-1:0] skid_q, skid_d;
    logic [EW-1:0] in_ent;
    logic          in_fire, out_fire;

    assign in_ent    = {in_inst, in_pc, in_data};
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign occupancy = state_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_ent;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_ent;
                end else if (in_fire) begin
                    skid_d  = in_ent;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Payload may still load during a flush; the output mux hides it.
        if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_inst = out_valid ? main_q[EW-1 -: 32]     : NOP_INST;
    assign out_pc   = out_valid ? main_q[DATA_W +: XLEN] : '0;
    assign out_data = out_valid ? main_q[DATA_W-1:0]     : '0;

`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
